mult_result_checker: RTL and testbench

MULT_RESULT_CHECKER -- requirements
Module: mult_result_checker

---
 rtl/mult_result_checker_if.sv | 36 +++
 rtl/mult_result_checker.sv | 197 +++++++++++++++++++
 tb/tb_mult_result_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_result_checker_if.sv
// Bundle of sample, status and mismatch-log signals for mult_result_checker.
// The master side drives samples and log_ready. The slave side (the checker) drives results and the log.
interface mult_result_checker_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
);
  logic                 start;
  logic [CNT_W-1:0]     n_tests;
  logic                 in_valid;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 cmp_valid;
  logic                 cmp_match;
  logic [CNT_W-1:0]     test_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 log_valid;
  logic                 log_ready;
  logic [4*WIDTH-1:0]   log_data;
  logic                 log_ovf;

  modport master (
    output start, n_tests, in_valid, A, B, P, log_ready,
    input  cmp_valid, cmp_match, test_cnt, err_cnt, busy, done, pass,
           log_valid, log_data, log_ovf
  );

  modport slave (
    input  start, n_tests, in_valid, A, B, P, log_ready,
    output cmp_valid, cmp_match, test_cnt, err_cnt, busy, done, pass,
           log_valid, log_data, log_ovf
  );
endinterface

// File: rtl/mult_result_checker.sv
// Checks P against A*B per sample (latency 1), counts tests/errors; mismatch log built only with MULT_CHK_LOG_EN.
// Samples are never stalled; the log drains via log_valid/log_ready and drops into sticky log_ovf when full.
`ifdef MULT_CHK_LOG_EN
module mult_result_checker_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, full, pop, push_ok;

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = !empty && pop_rdy;
    push_ok = push_vld && (!full || pop);
    drop    = push_vld && full && !pop;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop)     rd_d = rd_q + 1'b1;
    end
    pop_vld = !empty;
    pop_dat = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_q[AW-1:0]] <= push_dat;
  end
endmodule
`endif

module mult_result_checker #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  mult_result_checker_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   test_cnt_q, test_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               smp_vld_q, smp_vld_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d, gold_q, gold_d;
  logic [CNT_W:0]     in_flight;
  logic               start_ok, accept, mismatch;

  // At most one sample is in flight, so checked+pending caps acceptance at n_tests.
  always_comb begin
    start_ok  = io.start && (state_q != RUN);
    in_flight = {1'b0, test_cnt_q} + {{CNT_W{1'b0}}, smp_vld_q};
    accept    = (state_q == RUN) && io.in_valid && (in_flight != {1'b0, n_q});
    mismatch  = smp_vld_q && (p_q != gold_q);

    smp_vld_d = accept;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    gold_d    = gold_q;
    if (accept) begin
      a_d    = io.A;
      b_d    = io.B;
      p_d    = io.P;
      gold_d = {{WIDTH{1'b0}}, io.A} * {{WIDTH{1'b0}}, io.B};
    end

    state_d    = state_q;
    n_d        = n_q;
    test_cnt_d = test_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (smp_vld_q && (test_cnt_q != '1)) test_cnt_d = test_cnt_q + 1'b1;
    if (mismatch && (err_cnt_q != '1))   err_cnt_d  = err_cnt_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          n_d        = io.n_tests;
          test_cnt_d = '0;
          err_cnt_d  = '0;
          state_d    = (io.n_tests == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (smp_vld_q && (test_cnt_d == n_q)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      test_cnt_q <= '0;
      err_cnt_q  <= '0;
      smp_vld_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      gold_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      test_cnt_q <= test_cnt_d;
      err_cnt_q  <= err_cnt_d;
      smp_vld_q  <= smp_vld_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      gold_q     <= gold_d;
    end
  end

  assign io.cmp_valid = smp_vld_q;
  assign io.cmp_match = smp_vld_q && (p_q == gold_q);
  assign io.test_cnt  = test_cnt_q;
  assign io.err_cnt   = err_cnt_q;
  assign io.busy      = (state_q == RUN);
  assign io.done      = (state_q == DONE);
  assign io.pass      = (state_q == DONE) && (err_cnt_q == '0);

`ifdef MULT_CHK_LOG_EN
  logic               log_drop;
  logic               log_vld;
  logic [4*WIDTH-1:0] log_dat;
  logic               ovf_q, ovf_d;

  mult_result_checker_fifo #(
    .W     (4*WIDTH),
    .DEPTH (DEPTH)
  ) u_log (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .push_vld (mismatch),
    .push_dat ({a_q, b_q, p_q}),
    .pop_vld  (log_vld),
    .pop_rdy  (io.log_ready),
    .pop_dat  (log_dat),
    .drop     (log_drop)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (start_ok)      ovf_d = 1'b0;
    else if (log_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign io.log_valid = log_vld;
  assign io.log_data  = log_dat;
  assign io.log_ovf   = ovf_q;
`else
  logic unused_log;
  assign unused_log   = ^{io.log_ready, a_q, b_q, DEPTH[0]};
  assign io.log_valid = 1'b0;
  assign io.log_data  = '0;
  assign io.log_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_mult_result_checker.sv
// Self-checking bench for mult_result_checker: vector table, scoreboard on cmp_valid, and log/reset corner sequences.
module tb_mult_result_checker;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_result_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mult_result_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] p;
    logic       m;
  } vec_t;

  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] a, input logic [1:0] b,
                              input logic [3:0] p, input logic m);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.m = m;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [CNT_W-1:0] n);
    bus.start   = 1'b1;
    bus.n_tests = n;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send(input vec_t v);
    bus.in_valid = 1'b1;
    bus.A        = v.a;
    bus.B        = v.b;
    bus.P        = v.p;
    sb_q.push_back(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every cmp_valid must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && bus.cmp_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cmp_valid: got cmp_valid=1 expected no comparison at %0t", $time);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("cmp_match", 64'(bus.cmp_match), 64'(e.m));
      end
    end
  end

  initial begin
    vec_t tbl[8];
    vec_t mm[5];
    int   exp_err;

    tbl[0] = mk(2'd0, 2'd0, 4'd0, 1'b1);
    tbl[1] = mk(2'd3, 2'd3, 4'd9, 1'b1);
    tbl[2] = mk(2'd2, 2'd3, 4'd6, 1'b1);
    tbl[3] = mk(2'd3, 2'd2, 4'd5, 1'b0);
    tbl[4] = mk(2'd1, 2'd1, 4'd1, 1'b1);
    tbl[5] = mk(2'd0, 2'd3, 4'd3, 1'b0);
    tbl[6] = mk(2'd3, 2'd3, 4'd8, 1'b0);
    tbl[7] = mk(2'd2, 2'd1, 4'd2, 1'b1);
    mm[0]  = mk(2'd1, 2'd1, 4'd0, 1'b0);
    mm[1]  = mk(2'd1, 2'd2, 4'd3, 1'b0);
    mm[2]  = mk(2'd2, 2'd2, 4'd5, 1'b0);
    mm[3]  = mk(2'd3, 2'd1, 4'd1, 1'b0);
    mm[4]  = mk(2'd0, 2'd1, 4'd1, 1'b0);

    rst = 1'b1;
    bus.start = 1'b0; bus.n_tests = '0; bus.in_valid = 1'b0;
    bus.A = '0; bus.B = '0; bus.P = '0; bus.log_ready = 1'b0;
    tick(); tick();
    chk("reset_outputs", 64'({bus.cmp_valid, bus.cmp_match, bus.test_cnt, bus.err_cnt, bus.busy,
                              bus.done, bus.pass, bus.log_valid, bus.log_data, bus.log_ovf}), 64'd0);
    rst = 1'b0;
    tick();

    // in_valid in IDLE must not produce any comparison
    bus.in_valid = 1'b1; bus.A = 2'd1; bus.B = 2'd1; bus.P = 4'd0;
    tick(); tick();
    bus.in_valid = 1'b0;
    tick();
    chk("idle_test_cnt", 64'(bus.test_cnt), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // three matching samples back to back
    begin_run(3);
    chk("run_busy", 64'(bus.busy), 64'd1);
    send(mk(2'd1, 2'd2, 4'd2, 1'b1));
    send(mk(2'd2, 2'd2, 4'd4, 1'b1));
    send(mk(2'd3, 2'd3, 4'd9, 1'b1));
    tick();
    chk("basic_test_cnt", 64'(bus.test_cnt), 64'd3);
    chk("basic_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("basic_done_pass_busy", 64'({bus.done, bus.pass, bus.busy}), 64'b110);

    // vector table, with a start pulse mid-run that must be ignored
    begin_run(8);
    exp_err = 0;
    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].m) exp_err++;
      if (i == 3) begin
        bus.start   = 1'b1;
        bus.n_tests = 16'd1;
      end
      send(tbl[i]);
      bus.start = 1'b0;
    end
    tick();
    chk("table_test_cnt", 64'(bus.test_cnt), 64'd8);
    chk("table_err_cnt", 64'(bus.err_cnt), 64'(exp_err));
    chk("table_done_pass", 64'({bus.done, bus.pass}), 64'b10);
`ifdef MULT_CHK_LOG_EN
    chk("table_log_head", 64'(bus.log_data), 64'({tbl[3].a, tbl[3].b, tbl[3].p}));
`endif

    // zero-length run finishes immediately with pass
    begin_run(0);
    chk("zero_run_done_pass", 64'({bus.done, bus.pass, bus.busy}), 64'b110);
    chk("zero_run_test_cnt", 64'(bus.test_cnt), 64'd0);

    // single mismatch (3,1,P=2) with log_ready low
    begin_run(1);
    send(mk(2'd3, 2'd1, 4'd2, 1'b0));
    chk("mm_cmp_valid_match", 64'({bus.cmp_valid, bus.cmp_match}), 64'b10);
    tick();
    chk("mm_err_cnt", 64'(bus.err_cnt), 64'd1);
    chk("mm_done_pass", 64'({bus.done, bus.pass}), 64'b10);
`ifdef MULT_CHK_LOG_EN
    chk("mm_log_valid", 64'(bus.log_valid), 64'd1);
    chk("mm_log_data", 64'(bus.log_data), 64'hD2);
    chk("mm_log_ovf", 64'(bus.log_ovf), 64'd0);

    // five mismatches into a four-entry log: fifth dropped
    begin_run(5);
    for (int i = 0; i < 5; i++) send(mm[i]);
    tick();
    chk("ovf_err_cnt", 64'(bus.err_cnt), 64'd5);
    chk("ovf_flag", 64'(bus.log_ovf), 64'd1);
    bus.log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_log_valid", 64'(bus.log_valid), 64'd1);
      chk("ovf_log_order", 64'(bus.log_data), 64'({mm[i].a, mm[i].b, mm[i].p}));
      tick();
    end
    bus.log_ready = 1'b0;
    chk("ovf_log_empty", 64'(bus.log_valid), 64'd0);

    // full log, pop coinciding with the push: nothing lost
    begin_run(5);
    chk("restart_clears_ovf", 64'(bus.log_ovf), 64'd0);
    for (int i = 0; i < 5; i++) send(mm[i]);
    bus.log_ready = 1'b1;
    chk("pp_head", 64'(bus.log_data), 64'({mm[0].a, mm[0].b, mm[0].p}));
    tick();
    bus.log_ready = 1'b0;
    chk("pp_no_ovf", 64'(bus.log_ovf), 64'd0);
    bus.log_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("pp_log_order", 64'(bus.log_data), 64'({mm[i].a, mm[i].b, mm[i].p}));
      tick();
    end
    bus.log_ready = 1'b0;
    chk("pp_log_empty", 64'(bus.log_valid), 64'd0);
`else
    chk("nolog_log_valid", 64'(bus.log_valid), 64'd0);
    chk("nolog_log_data", 64'(bus.log_data), 64'd0);
    chk("nolog_log_ovf", 64'(bus.log_ovf), 64'd0);
`endif

    // reset mid-run after two of five samples
    begin_run(5);
    send(mk(2'd1, 2'd3, 4'd3, 1'b1));
    send(mk(2'd2, 2'd1, 4'd0, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", 64'({bus.cmp_valid, bus.cmp_match, bus.test_cnt, bus.err_cnt, bus.busy,
                                     bus.done, bus.pass, bus.log_valid, bus.log_data, bus.log_ovf}), 64'd0);
    sb_q.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 2'($urandom_range(0, 3));
      bus.B = 2'($urandom_range(0, 3));
      bus.P = 4'($urandom_range(0, 15));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("post_reset_ignored", 64'({bus.test_cnt, bus.busy, bus.done}), 64'd0);
    begin_run(1);
    send(mk(2'd1, 2'd3, 4'd3, 1'b1));
    tick();
    chk("post_reset_run", 64'({bus.test_cnt, bus.done, bus.pass}), 64'({16'd1, 2'b11}));

    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
